// File: rtl/simple_cpu_pkg.sv
// Definitions shared by simple_controller and simple_datapath: opcodes, instruction
// field positions, constant-register count and controller state encodings.
package simple_cpu_pkg;

  localparam int INSTR_W        = 16;
  localparam int NUM_CONST_REGS = 8;

  localparam int OPC_LSB  = 13;
  localparam int DEST_LSB = 9;
  localparam int REGA_LSB = 5;
  localparam int REGB_LSB = 1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_SHR  = 3'd3;
  localparam logic [2:0] OP_MOV  = 3'd4;
  localparam logic [2:0] OP_BGT  = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_FETCH  = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_DONE   = 3'd5
  } ctrl_state_t;

  // Opcodes 0..4 all write their result back to dest.
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op <= OP_MOV);
  endfunction

endpackage

// File: rtl/simple_instr_decode.sv
// Combinational instruction decoder: splits an instruction word into its fields
// and classifies it as ALU, branch or halt.
module simple_instr_decode
  import simple_cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [2:0]         opcode,
  output logic [3:0]         dest,
  output logic [3:0]         reg_a,
  output logic [3:0]         reg_b,
  output logic               is_alu,
  output logic               is_branch,
  output logic               is_halt
);

  // Bit 0 is reserved in the instruction format.
  logic unused_reserved;
  assign unused_reserved = instr[0];

  always_comb begin
    opcode    = instr[OPC_LSB +: 3];
    dest      = instr[DEST_LSB +: 4];
    reg_a     = instr[REGA_LSB +: 4];
    reg_b     = instr[REGB_LSB +: 4];
    is_alu    = is_alu_op(opcode);
    is_branch = (opcode == OP_BGT) || (opcode == OP_BEQ);
    is_halt   = (opcode == OP_HALT);
  end

endmodule

// File: rtl/simple_controller.sv
// Program sequencer for simple_datapath: IDLE -> LOAD -> (FETCH -> DECODE -> EXEC)* -> DONE.
// Optional CTRL_WATCHDOG_EN aborts a run after WDOG_LIMIT executed instructions.
module simple_controller
  import simple_cpu_pkg::*;
#(
  parameter int PC_WIDTH    = 4,
  parameter int INSTR_WIDTH = 16
`ifdef CTRL_WATCHDOG_EN
  , parameter int WDOG_LIMIT = 255
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [2:0]             opcode,
  output logic [3:0]             reg_a_sel,
  output logic [3:0]             reg_b_sel,
  output logic [3:0]             dest_reg,
  output logic                   reg_write,
  output logic                   load_operands,
  input  logic                   zero_flag,
  input  logic                   equal_flag,
  input  logic                   greater_flag,
  output logic                   timeout
);

  ctrl_state_t state, next_state;

  logic [PC_WIDTH-1:0]    pc;
  logic [INSTR_WIDTH-1:0] ir;
  logic [PC_WIDTH-1:0]    pc_next_seq;
  logic [PC_WIDTH-1:0]    branch_target;
  logic                   branch_taken;
  logic                   wdog_abort;

  logic [2:0] dec_opcode;
  logic [3:0] dec_dest;
  logic [3:0] dec_a;
  logic [3:0] dec_b;
  logic       dec_alu;
  logic       dec_branch;
  logic       dec_halt;

  // Reserved for a future branch-on-zero opcode.
  logic unused_zero;
  assign unused_zero = zero_flag;

  simple_instr_decode u_decode (
    .instr     (ir[INSTR_W-1:0]),
    .opcode    (dec_opcode),
    .dest      (dec_dest),
    .reg_a     (dec_a),
    .reg_b     (dec_b),
    .is_alu    (dec_alu),
    .is_branch (dec_branch),
    .is_halt   (dec_halt)
  );

  assign pc_next_seq   = pc + 1'b1;
  assign branch_target = PC_WIDTH'(dec_dest);
  assign branch_taken  = dec_branch && ((dec_opcode == OP_BGT) ? greater_flag : equal_flag);

  // Selects come straight from ir, so they hold the last instruction outside EXEC.
  assign imem_addr = pc;
  assign opcode    = dec_opcode;
  assign reg_a_sel = dec_a;
  assign reg_b_sel = dec_b;
  assign dest_reg  = dec_dest;

`ifdef CTRL_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ST_LOAD)
        wdog_cnt <= '0;
      else if (state == ST_EXEC)
        wdog_cnt <= wdog_cnt + 1'b1;
      if (state == ST_IDLE && start)
        timeout_q <= 1'b0;
      else if (wdog_abort)
        timeout_q <= 1'b1;
    end
  end

  // The current EXEC is the WDOG_LIMIT-th one when the count shows LIMIT-1.
  assign wdog_abort = (state == ST_EXEC) && !dec_halt &&
                      (wdog_cnt == WDOG_W'(WDOG_LIMIT - 1));
  assign timeout    = timeout_q;
`else
  assign wdog_abort = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start) next_state = ST_LOAD;
      ST_LOAD:   next_state = ST_FETCH;
      ST_FETCH:  next_state = ST_DECODE;
      ST_DECODE: next_state = ST_EXEC;
      ST_EXEC:   next_state = (dec_halt || wdog_abort) ? ST_DONE : ST_FETCH;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state == ST_LOAD) || (state == ST_FETCH) ||
                    (state == ST_DECODE) || (state == ST_EXEC);
    done          = (state == ST_DONE);
    load_operands = (state == ST_LOAD);
    reg_write     = (state == ST_EXEC) && dec_alu;
  end

  // ROM data is registered by the ROM, so it is captured one state after FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
      ir <= '0;
    end else begin
      case (state)
        ST_LOAD:   pc <= '0;
        ST_DECODE: ir <= imem_data;
        ST_EXEC:   if (!dec_halt) pc <= branch_taken ? branch_target : pc_next_seq;
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_controller.sv
// Self-checking bench for simple_controller with a behavioural ROM and datapath model.
// Define CTRL_WATCHDOG_EN to add the watchdog-abort vectors.
module tb_simple_controller;
  import simple_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, reg_write, load_operands, timeout;
  logic [3:0]  imem_addr;
  logic [15:0] imem_data = '0;
  logic [2:0]  opcode;
  logic [3:0]  reg_a_sel, reg_b_sel, dest_reg;
  logic        zero_flag, equal_flag, greater_flag;

  int checks = 0;
  int errors = 0;

  simple_controller #(
    .PC_WIDTH    (4),
    .INSTR_WIDTH (16)
`ifdef CTRL_WATCHDOG_EN
    , .WDOG_LIMIT (10)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .opcode        (opcode),
    .reg_a_sel     (reg_a_sel),
    .reg_b_sel     (reg_b_sel),
    .dest_reg      (dest_reg),
    .reg_write     (reg_write),
    .load_operands (load_operands),
    .zero_flag     (zero_flag),
    .equal_flag    (equal_flag),
    .greater_flag  (greater_flag),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  // Program ROM with one cycle of read latency.
  logic [15:0] rom [16];
  always @(posedge clk) imem_data <= rom[imem_addr];

  // Datapath model: R0..R7 read as their own index, R8/R9 operands, R10 result.
  logic [15:0] regs [16];
  logic [15:0] op_a = '0, op_b = '0;
  logic [15:0] val_a, val_b;
  int          write_count = 0;

  assign val_a        = (reg_a_sel < 4'(NUM_CONST_REGS)) ? 16'(reg_a_sel) : regs[reg_a_sel];
  assign val_b        = (reg_b_sel < 4'(NUM_CONST_REGS)) ? 16'(reg_b_sel) : regs[reg_b_sel];
  assign zero_flag    = (val_a == 16'd0);
  assign equal_flag   = (val_a == val_b);
  assign greater_flag = (val_a > val_b);

  function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SHL:  return a << 1;
      OP_SHR:  return a >> 1;
      default: return a;
    endcase
  endfunction

  always @(posedge clk) begin
    if (load_operands) begin
      regs[8]     <= op_a;
      regs[9]     <= op_b;
      regs[10]    <= '0;
      write_count <= 0;
    end else if (reg_write) begin
      write_count <= write_count + 1;
      if (dest_reg >= 4'(NUM_CONST_REGS))
        regs[dest_reg] <= alu(opcode, val_a, val_b);
    end
  end

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [3:0] d,
                                      input logic [3:0] a, input logic [3:0] b);
    return {op, d, a, b, 1'b0};
  endfunction

  typedef struct {
    string             name;
    logic [15:0][15:0] code;
    logic [15:0]       a;
    logic [15:0]       b;
    int                r10;
    int                writes;
    int                cycles;
    int                tout;
    int                chk_cyc;
    int                chk_addr;
    bit                poke;
  } vec_t;

  typedef struct {
    string name;
    int    r10;
    int    writes;
    int    cycles;
    int    tout;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];

  function automatic vec_t newRow(input string name, input int a, input int b);
    vec_t v;
    v.name     = name;
    v.code     = {16{enc(OP_HALT, 4'd0, 4'd0, 4'd0)}};
    v.a        = 16'(a);
    v.b        = 16'(b);
    v.r10      = 0;
    v.writes   = 0;
    v.cycles   = 8;
    v.tout     = 0;
    v.chk_cyc  = 5;
    v.chk_addr = 1;
    v.poke     = 1'b0;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkResult(input int cyc);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty: got done with no expectation queued, expected none");
      return;
    end
    e = sb_q.pop_front();
    checkOutput({e.name, "_r10"}, 32'(regs[10]), e.r10);
    checkOutput({e.name, "_writes"}, write_count, e.writes);
    checkOutput({e.name, "_done_cycle"}, cyc, e.cycles);
    checkOutput({e.name, "_timeout"}, 32'(timeout), e.tout);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_reg_write"}, 32'(reg_write), 0);
    checkOutput({tag, "_load_operands"}, 32'(load_operands), 0);
    checkOutput({tag, "_timeout"}, 32'(timeout), 0);
    checkOutput({tag, "_selects"}, {17'd0, opcode, reg_a_sel, reg_b_sel, dest_reg}, 0);
    checkOutput({tag, "_imem_addr"}, 32'(imem_addr), 0);
  endtask

  task automatic loadProgram(input vec_t v);
    for (int i = 0; i < 16; i++) rom[i] = v.code[i];
    op_a = v.a;
    op_b = v.b;
  endtask

  task automatic applyStimulus(input vec_t v);
    int cyc;
    bit finished;
    exp_t e;
    loadProgram(v);
    e.name   = v.name;
    e.r10    = v.r10;
    e.writes = v.writes;
    e.cycles = v.cycles;
    e.tout   = v.tout;
    sb_q.push_back(e);
    @(negedge clk);
    start    = 1'b1;
    cyc      = 0;
    finished = 1'b0;
    while (!finished && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        checkOutput({v.name, "_load_cycle1"}, 32'(load_operands), 1);
        checkOutput({v.name, "_busy_cycle1"}, 32'(busy), 1);
      end
      if (cyc == v.chk_cyc) checkOutput({v.name, "_imem_addr"}, 32'(imem_addr), v.chk_addr);
      if (done) begin
        checkResult(cyc);
        finished = 1'b1;
      end
      // Optional stray start pulses: one mid-run, one in the DONE cycle.
      start = (v.poke && (cyc == 3 || cyc == v.cycles)) ? 1'b1 : 1'b0;
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_no_done: got no done in %0d cycles, expected done", v.name, cyc);
      void'(sb_q.pop_front());
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput({v.name, "_busy_after"}, 32'(busy), 0);
    @(negedge clk);
    checkOutput({v.name, "_idle_after"}, 32'({busy, load_operands}), 0);
  endtask

  initial begin
    vec_t v;

    v = newRow("halt_only", 3, 5);
    v.cycles = 5; v.chk_cyc = 2; v.chk_addr = 0;
    tbl.push_back(v);

    v = newRow("add", 3, 5);
    v.code[0] = enc(OP_ADD, 4'd10, 4'd8, 4'd9);
    v.r10 = 8; v.writes = 1; v.poke = 1'b1;
    tbl.push_back(v);

    v = newRow("sub", 3, 5);
    v.code[0] = enc(OP_SUB, 4'd10, 4'd9, 4'd8);
    v.r10 = 2; v.writes = 1;
    tbl.push_back(v);

    v = newRow("shl", 3, 5);
    v.code[0] = enc(OP_SHL, 4'd10, 4'd8, 4'd0);
    v.r10 = 6; v.writes = 1;
    tbl.push_back(v);

    v = newRow("shr", 3, 5);
    v.code[0] = enc(OP_SHR, 4'd10, 4'd9, 4'd0);
    v.r10 = 2; v.writes = 1;
    tbl.push_back(v);

    v = newRow("mov", 3, 5);
    v.code[0] = enc(OP_MOV, 4'd10, 4'd9, 4'd0);
    v.r10 = 5; v.writes = 1;
    tbl.push_back(v);

    v = newRow("beq_taken", 3, 5);
    v.code[0] = enc(OP_BEQ, 4'd4, 4'd0, 4'd0);
    for (int i = 1; i < 4; i++) v.code[i] = enc(OP_ADD, 4'd10, 4'd8, 4'd9);
    v.chk_addr = 4;
    tbl.push_back(v);

    v = newRow("bgt_not_taken", 3, 5);
    v.code[0] = enc(OP_BGT, 4'd5, 4'd1, 4'd2);
    v.code[1] = enc(OP_ADD, 4'd10, 4'd8, 4'd9);
    v.code[5] = enc(OP_SUB, 4'd10, 4'd9, 4'd8);
    v.r10 = 8; v.writes = 1; v.cycles = 11;
    tbl.push_back(v);

    v = newRow("bgt_taken", 3, 5);
    v.code[0] = enc(OP_BGT, 4'd5, 4'd2, 4'd1);
    v.code[1] = enc(OP_ADD, 4'd10, 4'd8, 4'd9);
    v.code[5] = enc(OP_SUB, 4'd10, 4'd9, 4'd8);
    v.r10 = 2; v.writes = 1; v.cycles = 11; v.chk_addr = 5;
    tbl.push_back(v);

    v = newRow("write_const_reg", 3, 5);
    v.code[0] = enc(OP_ADD, 4'd3, 4'd8, 4'd9);
    v.writes = 1;
    tbl.push_back(v);

    v = newRow("pc_wrap", 3, 5);
    v.code[0]  = enc(OP_BEQ, 4'd15, 4'd10, 4'd0);
    v.code[15] = enc(OP_ADD, 4'd10, 4'd8, 4'd9);
    v.r10 = 8; v.writes = 1; v.cycles = 14; v.chk_cyc = 8; v.chk_addr = 0;
    tbl.push_back(v);

    // Shift-add multiply: R10 += R8 for each set bit of R9, shifting R8 left.
    v = newRow("multiply", 13, 11);
    v.code[0] = enc(OP_BEQ, 4'd8, 4'd9, 4'd0);
    v.code[1] = enc(OP_SHR, 4'd11, 4'd9, 4'd0);
    v.code[2] = enc(OP_SHL, 4'd12, 4'd11, 4'd0);
    v.code[3] = enc(OP_BEQ, 4'd5, 4'd12, 4'd9);
    v.code[4] = enc(OP_ADD, 4'd10, 4'd10, 4'd8);
    v.code[5] = enc(OP_SHL, 4'd8, 4'd8, 4'd0);
    v.code[6] = enc(OP_MOV, 4'd9, 4'd11, 4'd0);
    v.code[7] = enc(OP_BEQ, 4'd0, 4'd0, 4'd0);
    v.r10 = 143; v.writes = 19; v.cycles = 101;
    tbl.push_back(v);

`ifdef CTRL_WATCHDOG_EN
    v = newRow("watchdog", 3, 5);
    v.code[0] = enc(OP_BEQ, 4'd0, 4'd0, 4'd0);
    v.cycles = 32; v.tout = 1; v.chk_addr = 0;
    tbl.push_back(v);
    tbl.push_back(tbl[1]);
`endif

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) applyStimulus(tbl[i]);

    // Asynchronous reset while an ADD is executing.
    loadProgram(tbl[1]);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrun_exec_reg_write", 32'(reg_write), 1);
    checkOutput("midrun_exec_selects", {20'd0, reg_a_sel, reg_b_sel, dest_reg}, {20'd0, 4'd8, 4'd9, 4'd10});
    rst_n = 1'b0;
    #1;
    checkAllZero("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrun_no_write", write_count, 0);

    applyStimulus(tbl[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish by 200000, expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
